// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 receive/transmit links.
// Holds the receiver state encoding, parity modes and tick divider math.
package rs232_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Rounded clocks per oversample tick.
   function automatic int div_calc(
      input int clk_hz,
      input int baud,
      input int os
   );
      return (clk_hz + (baud * os) / 2) / (baud * os);
   endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks.
// A restart zeroes the phase so ticks align to a detected edge.
module rs232_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (restart || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/rs232_rx_link.sv
// RS-232 receiver: 16x oversampled majority vote, parity/frame/overrun
// detection and a valid/ready output register.
module rs232_rx_link
   import rs232_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 rs_232_txd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 overrun,
   input  logic                 clear_errors,
   output logic                 busy
);

   localparam int DIV = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [TW-1:0] T_A   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_B   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_D   = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t state, state_n;

   logic                 rx_s1, rx_s2, rx_s3;
   logic                 fall, tick, restart;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] sh;
   logic                 va, vb, vote;
   logic                 decide, bit_end;
   logic                 shift, par_chk, complete;
   logic                 par_err, exp_par;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rs_232_txd;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign fall    = rx_s3 & ~rx_s2;
   assign decide  = tick && (tick_cnt == T_D);
   assign bit_end = tick && (tick_cnt == T_END);
   assign vote    = (va & vb) | (va & rx_s2) | (vb & rx_s2);
   assign exp_par = (PARITY == PAR_ODD) ? ~^sh : ^sh;
   assign busy    = (state != ST_IDLE);

   rs232_baud_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .restart(restart),
      .tick   (tick)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      restart  = 1'b0;
      shift    = 1'b0;
      par_chk  = 1'b0;
      complete = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fall) begin
               state_n = ST_START;
               restart = 1'b1;
            end
         end
         ST_START: begin
            if (decide && vote)
               state_n = ST_IDLE;
            else if (bit_end)
               state_n = ST_DATA;
         end
         ST_DATA: begin
            shift = decide;
            if (bit_end && bit_cnt == LAST_BIT)
               state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            par_chk = decide;
            if (bit_end)
               state_n = ST_STOP;
         end
         ST_STOP: begin
            // Leave at mid-stop so the next start edge is not missed.
            if (decide) begin
               complete = 1'b1;
               state_n  = vote ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (rx_s2)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         sh       <= '0;
         va       <= 1'b1;
         vb       <= 1'b1;
         par_err  <= 1'b0;
      end else begin
         if (restart) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_err  <= 1'b0;
         end else begin
            if (tick)
               tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
            if (state == ST_DATA && bit_end)
               bit_cnt <= bit_cnt + 1'b1;
         end
         if (tick && tick_cnt == T_A)
            va <= rx_s2;
         if (tick && tick_cnt == T_B)
            vb <= rx_s2;
         if (shift)
            sh <= {vote, sh[DATA_BITS-1:1]};
         if (par_chk)
            par_err <= (vote != exp_par);
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (complete && (!rx_valid || rx_ready)) begin
            rx_data       <= sh;
            rx_frame_err  <= ~vote;
            rx_parity_err <= par_err;
            rx_valid      <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (complete && rx_valid && !rx_ready)
            overrun <= 1'b1;
         else if (clear_errors)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rs232_rx_link.sv
// Scoreboard bench for rs232_rx_link: 8N1 and 8E1 instances at DIV = 4,
// directed corner cases plus randomized frames against a frame-level model.
module tb_rs232_rx_link;

   localparam int BT = 64;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       txd0 = 1'b1, txd1 = 1'b1;
   logic       rdy0 = 1'b0, rdy1 = 1'b0;
   logic       clr0 = 1'b0, clr1 = 1'b0;
   logic [7:0] data0, data1;
   logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

   bit   auto0 = 1'b0, auto1 = 1'b0;
   int   n_cmp = 0, n_bad = 0;
   exp_t q0[$], q1[$];
   exp_t e0, e1;

   always #5 clk = ~clk;

   rs232_rx_link #(
      .CLK_HZ(7_372_800), .BAUD(115200), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY(0)
   ) u_dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .rs_232_txd(txd0),
      .rx_data(data0), .rx_valid(v0), .rx_ready(rdy0),
      .rx_frame_err(fe0), .rx_parity_err(pe0), .overrun(ov0),
      .clear_errors(clr0), .busy(busy0)
   );

   rs232_rx_link #(
      .CLK_HZ(7_372_800), .BAUD(115200), .OVERSAMPLE(16),
      .DATA_BITS(8), .PARITY(2)
   ) u_par (
      .clk_clk(clk), .reset_reset_n(rst_n), .rs_232_txd(txd1),
      .rx_data(data1), .rx_valid(v1), .rx_ready(rdy1),
      .rx_frame_err(fe1), .rx_parity_err(pe1), .overrun(ov1),
      .clear_errors(clr1), .busy(busy1)
   );

   // Frame-level reference: what a correct receiver reports for a frame.
   function automatic exp_t model(input logic [7:0] d, input bit use_par,
                                  input bit pbit, input bit stop_ok);
      exp_t e;
      e.d  = d;
      e.fe = !stop_ok;
      e.pe = use_par ? (pbit != ($countones(d) % 2 == 1)) : 1'b0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int inst, input logic b, input int bits);
      if (inst == 0) txd0 = b;
      else txd1 = b;
      repeat (bits * BT) @(negedge clk);
   endtask

   task automatic send(input int inst, input logic [7:0] d, input bit use_par,
                       input bit pbit, input int stop_low);
      drive(inst, 1'b0, 1);
      for (int i = 0; i < 8; i++) drive(inst, d[i], 1);
      if (use_par) drive(inst, pbit, 1);
      if (stop_low > 0) drive(inst, 1'b0, stop_low);
      drive(inst, 1'b1, 1);
   endtask

   task automatic ack(input int inst);
      @(posedge clk);
      #1;
      if (inst == 0) rdy0 = 1'b1;
      else rdy1 = 1'b1;
      @(posedge clk);
      #1;
      if (inst == 0) rdy0 = 1'b0;
      else rdy1 = 1'b0;
   endtask

   task automatic wait_valid0(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (v0) begin
            seen = 1'b1;
            break;
         end
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   always @(negedge clk) begin
      if (v0 && rdy0) begin
         n_cmp++;
         if (q0.size() == 0) begin
            n_bad++;
            $display("FAIL out0_unexpected: got %0h, expected none", data0);
         end else begin
            e0 = q0.pop_front();
            if ({data0, fe0, pe0} !== e0) begin
               n_bad++;
               $display("FAIL out0: got d=%0h fe=%0b pe=%0b, expected d=%0h fe=%0b pe=%0b",
                        data0, fe0, pe0, e0.d, e0.fe, e0.pe);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (v1 && rdy1) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL out1_unexpected: got %0h, expected none", data1);
         end else begin
            e1 = q1.pop_front();
            if ({data1, fe1, pe1} !== e1) begin
               n_bad++;
               $display("FAIL out1: got d=%0h fe=%0b pe=%0b, expected d=%0h fe=%0b pe=%0b",
                        data1, fe1, pe1, e1.d, e1.fe, e1.pe);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (auto0 && v0 && !rdy0) begin
         repeat ($urandom_range(0, 30)) @(posedge clk);
         ack(0);
      end
   end

   initial forever begin
      @(negedge clk);
      if (auto1 && v1 && !rdy1) begin
         repeat ($urandom_range(0, 30)) @(posedge clk);
         ack(1);
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      bit         ok, pb, seen;

      repeat (3) @(negedge clk);
      chk("reset0", 32'({busy0, v0, fe0, pe0, ov0, data0}), 32'd0);
      chk("reset1", 32'({busy1, v1, fe1, pe1, ov1, data1}), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: clean 8N1 frame, manual handshake
      q0.push_back(model(8'hA5, 0, 0, 1));
      send(0, 8'hA5, 0, 0, 0);
      wait_valid0("t1_valid");
      chk("t1_data", 32'(data0), 32'hA5);
      chk("t1_flags", 32'({fe0, pe0, ov0}), 32'd0);
      @(posedge clk);
      #1 rdy0 = 1'b1;
      @(negedge clk);
      chk("t1_hold", 32'(v0), 32'd1);
      @(posedge clk);
      #1 rdy0 = 1'b0;
      @(negedge clk);
      chk("t1_drop", 32'(v0), 32'd0);
      auto0 = 1'b1;

      // 2: start glitch of 3 ticks
      txd0 = 1'b0;
      repeat (6) @(negedge clk);
      chk("t2_busy_on", 32'(busy0), 32'd1);
      repeat (6) @(negedge clk);
      txd0 = 1'b1;
      repeat (18) @(negedge clk);
      chk("t2_busy_mid", 32'(busy0), 32'd1);
      repeat (20) @(negedge clk);
      chk("t2_busy_off", 32'(busy0), 32'd0);
      repeat (40) @(negedge clk);

      // 3: long break on stop bit, then clean frame
      q0.push_back(model(8'h3C, 0, 0, 0));
      fork
         send(0, 8'h3C, 0, 0, 2);
         begin
            repeat (680) @(negedge clk);
            chk("t3_break_busy", 32'(busy0), 32'd1);
         end
      join
      repeat (10) @(negedge clk);
      chk("t3_idle", 32'(busy0), 32'd0);
      q0.push_back(model(8'h55, 0, 0, 1));
      send(0, 8'h55, 0, 0, 0);
      repeat (100) @(negedge clk);

      // 5a: back-to-back with no consumer -> overrun
      auto0 = 1'b0;
      q0.push_back(model(8'h11, 0, 0, 1));
      send(0, 8'h11, 0, 0, 0);
      send(0, 8'h22, 0, 0, 0);
      repeat (100) @(negedge clk);
      chk("t5_overrun", 32'(ov0), 32'd1);
      chk("t5_held", 32'({v0, data0}), 32'h111);
      @(posedge clk);
      #1 clr0 = 1'b1;
      @(posedge clk);
      #1 clr0 = 1'b0;
      @(negedge clk);
      chk("t5_cleared", 32'(ov0), 32'd0);
      ack(0);
      repeat (20) @(negedge clk);

      // 5b: accept the held byte on the completion cycle of the next
      q0.push_back(model(8'h11, 0, 0, 1));
      q0.push_back(model(8'h22, 0, 0, 1));
      fork
         begin
            send(0, 8'h11, 0, 0, 0);
            send(0, 8'h22, 0, 0, 0);
         end
         begin
            seen = 1'b0;
            for (int i = 0; i < 2000; i++) begin
               @(negedge clk);
               if (v0) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("t5b_first", 32'(seen), 32'd1);
            seen = 1'b0;
            for (int i = 0; i < 2000; i++) begin
               @(negedge clk);
               if (busy0) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("t5b_second", 32'(seen), 32'd1);
            repeat (615) @(posedge clk);
            #1 rdy0 = 1'b1;
            @(posedge clk);
            #1 rdy0 = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      chk("t5b_no_overrun", 32'(ov0), 32'd0);
      chk("t5b_loaded", 32'({v0, data0}), 32'h122);
      ack(0);
      repeat (10) @(negedge clk);
      auto0 = 1'b1;

      // 6: reset in the middle of a data field
      fork
         send(0, 8'hFF, 0, 0, 0);
         begin
            repeat (3 * BT) @(negedge clk);
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            chk("t6_reset", 32'({busy0, v0}), 32'd0);
            rst_n = 1'b1;
         end
      join
      q0.push_back(model(8'h81, 0, 0, 1));
      send(0, 8'h81, 0, 0, 0);
      repeat (100) @(negedge clk);

      // random 8N1 frames, occasional stop-bit error
      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         q0.push_back(model(d, 0, 0, ok));
         send(0, d, 0, 0, ok ? 0 : 1);
         repeat ($urandom_range(0, 63)) @(negedge clk);
      end
      repeat (200) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("ov0_final", 32'(ov0), 32'd0);

      // 4: even parity instance
      auto1 = 1'b1;
      q1.push_back(model(8'h07, 1, 0, 1));
      send(1, 8'h07, 1, 1'b0, 0);
      q1.push_back(model(8'h07, 1, 1, 1));
      send(1, 8'h07, 1, 1'b1, 0);
      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         pb = 1'($urandom);
         q1.push_back(model(d, 1, pb, 1));
         send(1, d, 1, pb, 0);
         repeat ($urandom_range(0, 63)) @(negedge clk);
      end
      repeat (200) @(negedge clk);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("ov1_final", 32'({ov1, busy1}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
